// File: rtl/dmem_pkg.sv
// Shared types and constants for the RV32 data-memory access stage.
// Used by dmem_lane_align and dmem_access_unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        LSU_LW  = 2'd0,
        LSU_LBU = 2'd1,
        LSU_SW  = 2'd2,
        LSU_SB  = 2'd3
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } dmem_state_t;

    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    function automatic logic is_store(input lsu_op_t op);
        return (op == LSU_SW) || (op == LSU_SB);
    endfunction

    function automatic logic is_byte(input lsu_op_t op);
        return (op == LSU_LBU) || (op == LSU_SB);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: byte enables and write data for the outgoing request,
// and the zero-extended load result for the returning read word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_st_op,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_ld_op,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    lsu_op_t    w_st_op;
    lsu_op_t    w_ld_op;
    logic [7:0] w_ld_byte;

    assign w_st_op = lsu_op_t'(i_st_op);
    assign w_ld_op = lsu_op_t'(i_ld_op);

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        w_ld_byte = i_rdata[7:0];
        case (i_ld_off)
            2'd1:    w_ld_byte = i_rdata[15:8];
            2'd2:    w_ld_byte = i_rdata[23:16];
            2'd3:    w_ld_byte = i_rdata[31:24];
            default: w_ld_byte = i_rdata[7:0];
        endcase
    end

    assign o_be      = is_byte(w_st_op) ? (4'b0001 << i_st_off) : 4'hF;
    assign o_wdata   = (w_st_op == LSU_SB) ? {4{i_wdata[7:0]}} : i_wdata;
    assign o_ld_data = (w_ld_op == LSU_LBU) ? {24'b0, w_ld_byte} : i_rdata;

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: request/grant/response handshake, response watchdog.
// Optional alignment trap for LW/SW enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        st_done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_op_t           w_req_op;
    logic              w_trap;
    logic              w_wdog_expired;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ld_data;

    dmem_state_t       r_state;
    lsu_op_t           r_op;
    logic [1:0]        r_off;
    logic [4:0]        r_rd;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [31:0]       r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [31:0]       r_wb_data;
    logic              r_st_done;
    logic              r_err;
    logic [1:0]        r_err_code;

    assign w_req_op = lsu_op_t'(req_op);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_trap = !is_byte(w_req_op) && (req_addr[1:0] != 2'b00);
`else
    assign w_trap = 1'b0;
`endif

    // The count runs 0..TIMEOUT_CYCLES-1; expiry is the last cycle still waiting.
    assign w_wdog_expired = (TIMEOUT_CYCLES != 0) && (r_wdog == WDOG_LAST);

    dmem_lane_align u_lane_align (
        .i_st_op   (req_op),
        .i_st_off  (req_addr[1:0]),
        .i_wdata   (req_wdata),
        .i_ld_op   (r_op),
        .i_ld_off  (r_off),
        .i_rdata   (mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_ld_data (w_ld_data)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= LSU_LW;
            r_off       <= 2'b00;
            r_rd        <= 5'd0;
            r_wdog      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_st_done   <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_wb_valid <= 1'b0;
            r_st_done  <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op   <= w_req_op;
                        r_off  <= req_addr[1:0];
                        r_rd   <= req_rd;
                        r_wdog <= '0;
                        if (w_trap) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_MISALIGN;
                        end else begin
                            r_state     <= REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= is_store(w_req_op);
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_wdog    <= '0;
                        if (is_store(r_op)) begin
                            r_state   <= IDLE;
                            r_st_done <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end else if (w_wdog_expired) begin
                        r_mem_req  <= 1'b0;
                        r_state    <= IDLE;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_state    <= IDLE;
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_ld_data;
                    end else if (w_wdog_expired) begin
                        r_state    <= IDLE;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign st_done   = r_st_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Data-memory access stage of the RV32 core: accepts a resolved load/store request (op, effective address, store data, destination register) from the address-generation stage. Runs a request/grant/response handshake with the data memory. Returns zero-extended load data to writeback or a store-complete pulse. Byte-lane steering for LBU/SB, alignment checking and a response watchdog are handled here, so memory sees only word-aligned accesses with byte enables.

## Interface
- TIMEOUT_CYCLES, 255: max cycles waiting in REQ or WAIT before abort; 0 disables the watchdog
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  upstream request valid
- req_ready  output  1  high exactly when state is IDLE
- req_op  input  2  lsu_op_t: LW=0, LBU=1, SW=2, SB=3
- req_addr  input  32  effective byte address
- req_wdata  input  32  store data (SB uses [7:0])
- req_rd  input  5  load destination register
- mem_req  output  1  memory request, held until mem_gnt
- mem_we  output  1  1=write
- mem_addr  output  32  word address, bits [1:0] always 0
- mem_be  output  4  byte enables
- mem_wdata  output  32  write data, lane-replicated for SB
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read data word
- wb_valid  output  1  one-cycle load result pulse
- wb_rd  output  5  destination register for wb_data
- wb_data  output  32  load result
- st_done  output  1  one-cycle store-complete pulse
- err  output  1  one-cycle error pulse
- err_code  output  2  1=misaligned, 2=timeout, valid while err=1

## Operation
- States: IDLE, REQ, WAIT. Reset (sync) → IDLE. All outputs are 0 after reset except req_ready=1. A reset in REQ/WAIT aborts: mem_req drops at that edge and no wb_valid/st_done/err is produced for the aborted access.
- Accept on req_valid && req_ready. Op, rd and byte offset addr[1:0] are latched. mem_addr={req_addr[31:2],2'b00}, mem_we, mem_be and mem_wdata are registered and stay stable through REQ.
- Lanes: LW/SW be=4'hF and wdata unchanged. SB be=4'b0001<<addr[1:0], wdata={4{req_wdata[7:0]}}. LBU be=4'b0001<<addr[1:0] and wb_data={24'b0, mem_rdata[8*off+:8]}. LW wb_data=mem_rdata.
- REQ: mem_req=1. On mem_gnt, a store → IDLE with st_done=1 and a load → WAIT.
- WAIT: mem_rvalid is sampled only here. A mem_rvalid that arrives in the same cycle as mem_gnt is ignored (the memory contract guarantees rvalid ≥1 cycle after gnt). On rvalid: wb_valid=1, wb_rd/wb_data set, → IDLE.
- Watchdog: the counter clears on entry to REQ and WAIT and increments each cycle in those states. When it reaches TIMEOUT_CYCLES without gnt or rvalid (respectively): err=1, err_code=2, mem_req deasserts, → IDLE, no wb/st_done. A gnt or rvalid in the same cycle as expiry wins; no error is raised.
- wb_valid, st_done and err are mutually exclusive and never asserted for more than one cycle.

## Timing
- Accept edge T0. mem_req high from T1. mem_gnt at T1 gives: store st_done at T2; load WAIT at T2, and with rvalid at T2, wb_valid at T3.
- Back-to-back: req_ready is high in the same cycle as st_done/wb_valid/err, so the next accept can occur at that edge.
- Each gnt-cycle stall adds one cycle, and each rvalid-cycle stall adds one cycle.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: LW/SW with addr[1:0]≠0 is accepted but not issued. The FSM stays IDLE, err=1 with err_code=1 on the cycle after accept, and mem_req is never raised. LBU/SB are never misaligned.
- Undefined: no alignment check. Misaligned LW/SW access the containing aligned word with be=4'hF, and err_code=1 is never produced.

## Structure
- Package dmem_pkg: lsu_op_t enum, dmem_state_t enum (IDLE/REQ/WAIT), ERR_MISALIGN=2'd1, ERR_TIMEOUT=2'd2.
- Sub-module dmem_lane_align (combinational): computes be/wdata from op, offset and wdata, and the load result from op, offset and rdata. The FSM, watchdog and registers live in dmem_access_unit.

## Test plan
- LW 0x0000_1008, gnt at T1, rvalid at T2 with rdata 0xDEAD_BEEF, rd=5 → mem_addr 0x1008, be F, wb_valid at T3 with wb_data 0xDEAD_BEEF and wb_rd 5.
- LBU 0x1003, rdata 0xAB12_3456 → be 4'b1000, wb_data 0x0000_00AB. SB 0x1001, wdata 0x77 → we=1, be 4'b0010, wdata 0x7777_7777, st_done at T2.
- SW with gnt withheld 3 cycles → mem_req and all mem outputs stable 4 cycles, st_done the cycle after gnt, req_ready low until then.
- TIMEOUT_CYCLES=4, LW with gnt but no rvalid → err=1, err_code=2 after 4 WAIT cycles, no wb_valid, next request accepted.
- DMEM_MISALIGN_TRAP_EN: SW 0x1002 → no mem_req, err_code=1 at T1. Without the macro → mem_addr 0x1000, be F, st_done.
- rst asserted in WAIT, then rvalid → IDLE next edge, outputs 0, no wb_valid.
